// File: rtl/bram_dual_port.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only, both read-first.
// A CLEAR/READY sweep zeroes the array; optional per-byte parity under BRAM_PARITY_EN.
module bram_dual_port #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                init_start,
   output logic                busy,
   input  logic                a_req,
   input  logic [DATA_W/8-1:0] a_we,
   input  logic [31:0]         a_addr,
   input  logic [DATA_W-1:0]   a_wdata,
   output logic [DATA_W-1:0]   a_rdata,
   output logic                a_rvalid,
   input  logic                b_req,
   input  logic [31:0]         b_addr,
   output logic [DATA_W-1:0]   b_rdata,
   output logic                b_rvalid,
   output logic                err_oor,
   input  logic                perr_inj,
   output logic                rd_perr
);

   localparam int unsigned NB     = DATA_W / 8;
   localparam int unsigned OFFS_W = $clog2(NB);
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [31:0]   a_idx, b_idx;
   logic [AW-1:0] a_widx, b_ridx;
   logic          a_oor, b_oor;
   logic          a_acc, b_acc, a_wr;
   logic          sweep_we;
   logic          a_perr_rd, b_perr_rd;

   logic              a_v1_q, b_v1_q;
   logic              a_oor1_q, b_oor1_q;
   logic              a_perr1_q, b_perr1_q;
   logic [DATA_W-1:0] a_d1_q, b_d1_q;

   assign a_idx  = a_addr >> OFFS_W;
   assign b_idx  = b_addr >> OFFS_W;
   assign a_widx = a_idx[AW-1:0];
   assign b_ridx = b_idx[AW-1:0];
   assign a_oor  = (a_idx >= 32'(DEPTH));
   assign b_oor  = (b_idx >= 32'(DEPTH));

   assign busy     = (state_q == StClear);
   assign a_acc    = a_req & ~busy;
   assign b_acc    = b_req & ~busy;
   assign a_wr     = a_acc & (|a_we) & ~a_oor;
   // rst gate keeps the sweep from touching word 0 while reset is held with a running clock
   assign sweep_we = busy & rst;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         StClear: begin
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
               state_d   = StReady;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         StReady: begin
            if (init_start) begin
               state_d   = StClear;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = StClear;
            clr_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Array contents carry no reset; only the sweep clears them.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (a_wr) begin
         for (int i = 0; i < NB; i++) begin
            if (a_we[i]) mem_q[a_widx][8*i +: 8] <= a_wdata[8*i +: 8];
         end
      end
   end

`ifdef BRAM_PARITY_EN
   logic [NB-1:0] par_q [DEPTH];

   function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] d);
      logic [NB-1:0] p;
      for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         par_q[clr_cnt_q] <= '0;
      end else if (a_wr) begin
         for (int i = 0; i < NB; i++) begin
            if (a_we[i]) par_q[a_widx][i] <= (^a_wdata[8*i +: 8]) ^ perr_inj;
         end
      end
   end

   assign a_perr_rd = |(par_q[a_widx] ^ byte_par(mem_q[a_widx]));
   assign b_perr_rd = |(par_q[b_ridx] ^ byte_par(mem_q[b_ridx]));
`else
   logic unused_perr_inj;
   assign unused_perr_inj = perr_inj;
   assign a_perr_rd       = 1'b0;
   assign b_perr_rd       = 1'b0;
`endif

   // First read stage; data holds while no access is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_v1_q    <= 1'b0;
         b_v1_q    <= 1'b0;
         a_oor1_q  <= 1'b0;
         b_oor1_q  <= 1'b0;
         a_perr1_q <= 1'b0;
         b_perr1_q <= 1'b0;
         a_d1_q    <= '0;
         b_d1_q    <= '0;
      end else begin
         a_v1_q    <= a_acc;
         b_v1_q    <= b_acc;
         a_oor1_q  <= a_acc & a_oor;
         b_oor1_q  <= b_acc & b_oor;
         a_perr1_q <= a_acc & ~a_oor & a_perr_rd;
         b_perr1_q <= b_acc & ~b_oor & b_perr_rd;
         if (a_acc) a_d1_q <= a_oor ? '0 : mem_q[a_widx];
         if (b_acc) b_d1_q <= b_oor ? '0 : mem_q[b_ridx];
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic              a_v2_q, b_v2_q;
      logic              a_oor2_q, b_oor2_q;
      logic              a_perr2_q, b_perr2_q;
      logic [DATA_W-1:0] a_d2_q, b_d2_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            a_v2_q    <= 1'b0;
            b_v2_q    <= 1'b0;
            a_oor2_q  <= 1'b0;
            b_oor2_q  <= 1'b0;
            a_perr2_q <= 1'b0;
            b_perr2_q <= 1'b0;
            a_d2_q    <= '0;
            b_d2_q    <= '0;
         end else begin
            a_v2_q    <= a_v1_q;
            b_v2_q    <= b_v1_q;
            a_oor2_q  <= a_oor1_q;
            b_oor2_q  <= b_oor1_q;
            a_perr2_q <= a_perr1_q;
            b_perr2_q <= b_perr1_q;
            if (a_v1_q) a_d2_q <= a_d1_q;
            if (b_v1_q) b_d2_q <= b_d1_q;
         end
      end

      assign a_rvalid = a_v2_q;
      assign b_rvalid = b_v2_q;
      assign a_rdata  = a_d2_q;
      assign b_rdata  = b_d2_q;
      assign err_oor  = a_oor2_q | b_oor2_q;
      assign rd_perr  = a_perr2_q | b_perr2_q;
   end else begin : g_lat1
      assign a_rvalid = a_v1_q;
      assign b_rvalid = b_v1_q;
      assign a_rdata  = a_d1_q;
      assign b_rdata  = b_d1_q;
      assign err_oor  = a_oor1_q | b_oor1_q;
      assign rd_perr  = a_perr1_q | b_perr1_q;
   end

endmodule

// File: tb/tb_bram_dual_port.sv
// Scoreboard bench for bram_dual_port: two instances (read latency 1 and 2) share one stimulus
// stream; a behavioural word-array model predicts every response.
module tb_bram_dual_port;

   localparam int unsigned DEPTH = 16;
`ifdef BRAM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        init_start = 1'b0;
   logic        a_req      = 1'b0;
   logic        b_req      = 1'b0;
   logic        perr_inj   = 1'b0;
   logic [3:0]  a_we       = '0;
   logic [31:0] a_addr     = '0;
   logic [31:0] a_wdata    = '0;
   logic [31:0] b_addr     = '0;

   logic [1:0]  busy, a_rvalid, b_rvalid, err_oor, rd_perr;
   logic [31:0] a_rdata [2];
   logic [31:0] b_rdata [2];

   bram_dual_port #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .init_start(init_start), .busy(busy[0]),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
      .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
      .err_oor(err_oor[0]), .perr_inj(perr_inj), .rd_perr(rd_perr[0])
   );

   bram_dual_port #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .init_start(init_start), .busy(busy[1]),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
      .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
      .err_oor(err_oor[1]), .perr_inj(perr_inj), .rd_perr(rd_perr[1])
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [31:0] data;
      logic        oor;
      logic        perr;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   int unsigned ptr [2][2];
   logic [31:0] last_d [2][2];

   logic [31:0] m_mem [DEPTH];
   logic [3:0]  m_bad [DEPTH];
   int unsigned m_clr_left = 0;
   logic        exp_busy   = 1'b1;

   int checks = 0;
   int errors = 0;

   function automatic exp_t model_read(input logic [31:0] addr);
      exp_t        e;
      int unsigned idx;
      idx    = addr >> 2;
      e.cyc  = cyc;
      e.oor  = (idx >= DEPTH);
      e.data = '0;
      e.perr = 1'b0;
      if (!e.oor) begin
         e.data = m_mem[idx];
         e.perr = PAR && (m_bad[idx] != 4'h0);
      end
      return e;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [3:0] we,
                              input logic [31:0] wd, input logic pinj);
      int unsigned idx;
      idx = addr >> 2;
      if (idx < DEPTH) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               m_mem[idx][8*i +: 8] = wd[8*i +: 8];
               m_bad[idx][i]        = pinj;
            end
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = '0;
         m_bad[i] = '0;
      end
   endtask

   // One clock: drive at posedge+1, predict, and advance the model across the next posedge.
   task automatic step(input logic ar, input logic [3:0] we, input logic [31:0] aa,
                       input logic [31:0] wd, input logic pinj, input logic br,
                       input logic [31:0] ba, input logic init);
      logic init_acc;
      a_req      = ar;
      a_we       = we;
      a_addr     = aa;
      a_wdata    = wd;
      perr_inj   = pinj;
      b_req      = br;
      b_addr     = ba;
      init_start = init;
      exp_busy   = (m_clr_left > 0);
      init_acc   = init && !exp_busy;
      if (!exp_busy) begin
         if (br) qb.push_back(model_read(ba));
         if (ar) begin
            qa.push_back(model_read(aa));
            model_write(aa, we, wd, pinj);
         end
      end
      @(posedge clk);
      #1;
      if (m_clr_left > 0) begin
         m_clr_left--;
      end else if (init_acc) begin
         m_clr_left = DEPTH;
         model_clear();
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset(input int unsigned hold);
      rst        = 1'b0;
      a_req      = 1'b0;
      b_req      = 1'b0;
      init_start = 1'b0;
      a_we       = '0;
      perr_inj   = 1'b0;
      exp_busy   = 1'b1;
      for (int j = 0; j < 2; j++) begin
         ptr[j][0]    = qa.size();
         ptr[j][1]    = qb.size();
         last_d[j][0] = '0;
         last_d[j][1] = '0;
      end
      repeat (hold) @(posedge clk);
      #1;
      rst        = 1'b1;
      m_clr_left = DEPTH;
      model_clear();
   endtask

   task automatic check_port(input int j, input int p, input logic v, input logic [31:0] d,
                             inout logic oe, inout logic pe);
      exp_t        e;
      int unsigned n, lat;
      bit          have;
      string       nm;
      nm   = $sformatf("dut%0d_%s", j + 1, (p == 1) ? "b" : "a");
      lat  = (j == 0) ? 1 : 2;
      n    = (p == 1) ? qb.size() : qa.size();
      have = ptr[j][p] < n;
      e    = '{cyc: 0, data: '0, oor: 1'b0, perr: 1'b0};
      if (have) begin
         if (p == 1) e = qb[ptr[j][p]];
         else        e = qa[ptr[j][p]];
      end
      checks++;
      if (v) begin
         if (!have) begin
            errors++;
            $display("FAIL %s unexpected rvalid: cycle %0d data %08h, no request pending",
                     nm, cyc, d);
         end else begin
            ptr[j][p]++;
            oe |= e.oor;
            pe |= e.perr;
            last_d[j][p] = e.data;
            if (cyc != e.cyc + lat || d !== e.data) begin
               errors++;
               $display("FAIL %s read: cycle %0d data %08h, required cycle %0d data %08h",
                        nm, cyc, d, e.cyc + lat, e.data);
            end
         end
      end else begin
         if (d !== last_d[j][p]) begin
            errors++;
            $display("FAIL %s hold: rdata %08h while idle, required %08h", nm, d, last_d[j][p]);
         end
         if (have && cyc > e.cyc + lat) begin
            errors++;
            ptr[j][p]++;
            $display("FAIL %s missing rvalid: none by cycle %0d, required at cycle %0d",
                     nm, cyc, e.cyc + lat);
         end
      end
   endtask

   always @(negedge clk) begin
      for (int j = 0; j < 2; j++) begin
         logic oe, pe;
         oe = 1'b0;
         pe = 1'b0;
         if (!rst) begin
            checks++;
            if (a_rvalid[j] || b_rvalid[j] || err_oor[j] || rd_perr[j] || !busy[j] ||
                a_rdata[j] != 32'h0 || b_rdata[j] != 32'h0) begin
               errors++;
               $display("FAIL dut%0d reset_state: rv %b/%b oor %b perr %b busy %b rd %08h/%08h",
                        j + 1, a_rvalid[j], b_rvalid[j], err_oor[j], rd_perr[j], busy[j],
                        a_rdata[j], b_rdata[j]);
            end
         end else begin
            check_port(j, 0, a_rvalid[j], a_rdata[j], oe, pe);
            check_port(j, 1, b_rvalid[j], b_rdata[j], oe, pe);
            checks++;
            if (err_oor[j] !== oe) begin
               errors++;
               $display("FAIL dut%0d err_oor: cycle %0d got %b, required %b", j + 1, cyc,
                        err_oor[j], oe);
            end
            checks++;
            if (rd_perr[j] !== pe) begin
               errors++;
               $display("FAIL dut%0d rd_perr: cycle %0d got %b, required %b", j + 1, cyc,
                        rd_perr[j], pe);
            end
            checks++;
            if (busy[j] !== exp_busy) begin
               errors++;
               $display("FAIL dut%0d busy: cycle %0d got %b, required %b", j + 1, cyc,
                        busy[j], exp_busy);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      for (int j = 0; j < 2; j++) begin
         ptr[j][0]    = 0;
         ptr[j][1]    = 0;
         last_d[j][0] = '0;
         last_d[j][1] = '0;
      end
      #2;
      do_reset(3);
      idle(DEPTH);
      // freshly swept word read back as zero
      step(1'b1, 4'h0, 32'h3C, '0, 1'b0, 1'b0, '0, 1'b0);
      // byte-enable merge
      step(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 4'h5, 32'h10, 32'h11223344, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 4'h0, '0, '0, 1'b0, 1'b1, 32'h10, 1'b0);
      // same-word A write / B read collision returns old data
      step(1'b1, 4'hF, 32'h20, 32'h5, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 1'b0, 1'b1, 32'h20, 1'b0);
      step(1'b0, 4'h0, '0, '0, 1'b0, 1'b1, 32'h20, 1'b0);
      // out-of-range write, read, and word 0 untouched
      step(1'b1, 4'hF, 32'h40, 32'h12345678, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 4'h0, 32'h40, '0, 1'b0, 1'b1, 32'h0, 1'b0);
      // back-to-back reads on both ports
      step(1'b1, 4'h0, 32'h0, '0, 1'b0, 1'b1, 32'h0, 1'b0);
      step(1'b1, 4'h0, 32'h4, '0, 1'b0, 1'b1, 32'h4, 1'b0);
      step(1'b1, 4'h0, 32'h8, '0, 1'b0, 1'b1, 32'h8, 1'b0);
      // parity fault injection, then clean rewrite
      step(1'b1, 4'h1, 32'h8, 32'hFF, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 4'h0, 32'h8, '0, 1'b0, 1'b1, 32'h8, 1'b0);
      step(1'b1, 4'h1, 32'h8, 32'hFF, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 4'h0, 32'h8, '0, 1'b0, 1'b1, 32'h8, 1'b0);
      idle(3);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] aa, ba;
         logic [3:0]  we;
         aa = 32'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
         ba = 32'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) aa = $urandom;
         if ($urandom_range(0, 15) == 0) ba = $urandom;
         we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         step(1'($urandom_range(0, 3) != 0), we, aa, $urandom, 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 2) != 0), ba, 1'($urandom_range(0, 63) == 0));
      end
      idle(DEPTH + 3);

      // reset with reads in flight: nothing may emerge afterwards
      step(1'b1, 4'h0, 32'h0, '0, 1'b0, 1'b1, 32'h4, 1'b0);
      do_reset(2);
      idle(DEPTH + 2);
      // reset mid-sweep restarts a full sweep
      step(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      idle(5);
      do_reset(2);
      idle(DEPTH + 2);
      step(1'b1, 4'h0, 32'h10, '0, 1'b0, 1'b1, 32'h20, 1'b0);
      idle(4);

      for (int j = 0; j < 2; j++) begin
         checks++;
         if (ptr[j][0] != qa.size() || ptr[j][1] != qb.size()) begin
            errors++;
            $display("FAIL dut%0d drain: consumed a %0d b %0d, required a %0d b %0d", j + 1,
                     ptr[j][0], ptr[j][1], qa.size(), qb.size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
